// File: rtl/fft_uart_pkg.sv
// fft_uart_pkg: state encoding and defaults for fft_frame_sequencer.
// FRAME_CHECKSUM_EN adds the CSUM state.
package fft_uart_pkg;

  localparam logic [7:0] DEF_HDR0 = 8'hAA;
  localparam logic [7:0] DEF_HDR1 = 8'h55;
  localparam int DEF_DATA_W = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  localparam int S_IDLE  = 0;
  localparam int S_HDR   = 1;
  localparam int S_FETCH = 2;
  localparam int S_LATCH = 3;
  localparam int S_SEND  = 4;
  localparam int S_FIN   = 5;
`ifdef FRAME_CHECKSUM_EN
  localparam int S_CSUM  = 6;
  localparam int NS      = 7;
`else
  localparam int NS      = 6;
`endif

  typedef enum logic [NS-1:0] {
    IDLE  = NS'(1 << S_IDLE),
    HDR   = NS'(1 << S_HDR),
    FETCH = NS'(1 << S_FETCH),
    LATCH = NS'(1 << S_LATCH),
    SEND  = NS'(1 << S_SEND),
`ifdef FRAME_CHECKSUM_EN
    CSUM  = NS'(1 << S_CSUM),
`endif
    FIN   = NS'(1 << S_FIN)
  } state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SKIP,
    F_WAIT
  } feed_t;

  function automatic int clog2_min1(
    input int v
  );
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_byte_feeder.sv
// uart_byte_feeder: owns the uart_start / uart_busy handshake.
// byte_ack fires in the cycle a requested byte is accepted.
module uart_byte_feeder
  import fft_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_busy,
  input  logic       byte_req,
  input  logic [7:0] byte_in,
  output logic       byte_ack,
  output logic       uart_start,
  output logic [7:0] uart_data
);

  feed_t fst, fnext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst        <= F_IDLE;
      uart_start <= 1'b0;
      uart_data  <= '0;
    end else begin
      fst        <= fnext;
      uart_start <= byte_ack;
      if (byte_ack) uart_data <= byte_in;
    end
  end

  // SKIP hides the cycle before the UART has raised busy
  always_comb begin
    fnext    = fst;
    byte_ack = 1'b0;
    unique case (fst)
      F_IDLE, F_WAIT: begin
        if (!uart_busy) begin
          if (byte_req) begin
            byte_ack = 1'b1;
            fnext    = F_SKIP;
          end else begin
            fnext = F_IDLE;
          end
        end
      end
      F_SKIP:  fnext = F_WAIT;
      default: fnext = F_IDLE;
    endcase
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: drains one FFT frame from the FIFO into uart_tx.
// Define FRAME_CHECKSUM_EN to append an 8-bit payload checksum.
module fft_frame_sequencer
  import fft_uart_pkg::*;
#(
  parameter int         FRAME_LEN = 512,
  parameter int         DATA_W    = DEF_DATA_W,
  parameter logic [7:0] HDR0      = DEF_HDR0,
  parameter logic [7:0] HDR1      = DEF_HDR1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              uart_busy,
  output logic              uart_start,
  output logic [7:0]        uart_data,
  output logic              busy,
  output logic              done
);

  localparam int BPW  = DATA_W / 8;
  localparam int BI_W = clog2_min1(BPW);
  localparam int WC_W = $clog2(FRAME_LEN + 1);
  localparam logic [BI_W-1:0] BI_ONE = BI_W'(1);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [BI_W-1:0] LAST_B = BI_W'(BPW - 1);
  localparam logic [WC_W-1:0] LAST_W = WC_W'(FRAME_LEN - 1);

  state_t state, next;
  logic              rx_prev;
  logic [DATA_W-1:0] word_reg;
  logic [BI_W-1:0]   byte_idx;
  logic [WC_W-1:0]   word_cnt;
  logic              byte_req, byte_ack;
  logic [7:0]        byte_out;
  logic              rise, last_byte, last_word;
  logic              tx_state;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign rise      = rx_ready & ~rx_prev;
  assign last_byte = (byte_idx == LAST_B);
  assign last_word = (word_cnt == LAST_W);
  assign busy      = ~(state[S_IDLE] | state[S_FIN]);
  assign done      = state[S_FIN];

`ifdef FRAME_CHECKSUM_EN
  assign tx_state = state[S_HDR] | state[S_SEND]
                  | state[S_CSUM];
`else
  assign tx_state = state[S_HDR] | state[S_SEND];
`endif

  // a dropped rx_ready blocks any new UART byte or FIFO read
  assign byte_req   = rx_ready & tx_state;
  assign fifo_rd_en = rx_ready & state[S_FETCH]
                    & ~fifo_empty;

  always_comb begin
    byte_out = word_reg[DATA_W-1 -: 8];
    if (state[S_HDR]) byte_out = byte_idx[0] ? HDR1 : HDR0;
`ifdef FRAME_CHECKSUM_EN
    if (state[S_CSUM]) byte_out = csum;
`endif
  end

  always_comb begin
    next = state;
    unique case (1'b1)
      state[S_IDLE]:  if (rise) next = HDR;
      state[S_HDR]:   if (byte_ack && byte_idx[0]) next = FETCH;
      state[S_FETCH]: if (!fifo_empty) next = LATCH;
      state[S_LATCH]: next = SEND;
      state[S_SEND]: begin
        if (byte_ack && last_byte) begin
          if (!last_word) next = FETCH;
`ifdef FRAME_CHECKSUM_EN
          else next = CSUM;
`else
          else next = FIN;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      state[S_CSUM]:  if (byte_ack) next = FIN;
`endif
      state[S_FIN]:   next = IDLE;
      default:        next = IDLE;
    endcase
    if (!state[S_IDLE] && !rx_ready) next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_prev  <= 1'b0;
      word_reg <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state   <= next;
      rx_prev <= rx_ready;
      if (state[S_IDLE]) begin
        byte_idx <= '0;
        word_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (state[S_LATCH]) begin
        word_reg <= fifo_dout;
        byte_idx <= '0;
      end
      if (byte_ack && state[S_HDR]) byte_idx <= byte_idx + BI_ONE;
      if (byte_ack && state[S_SEND]) begin
        word_reg <= word_reg << 8;
        if (!last_byte) byte_idx <= byte_idx + BI_ONE;
        if (last_byte && !last_word) word_cnt <= word_cnt + WC_ONE;
`ifdef FRAME_CHECKSUM_EN
        csum <= csum + byte_out;
`endif
      end
    end
  end

  uart_byte_feeder u_feeder (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_busy  (uart_busy),
    .byte_req   (byte_req),
    .byte_in    (byte_out),
    .byte_ack   (byte_ack),
    .uart_start (uart_start),
    .uart_data  (uart_data)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: scoreboard bench with FIFO and UART models.
// Follows FRAME_CHECKSUM_EN to expect the trailing checksum byte.
module tb_fft_frame_sequencer;

  localparam int FL = 3;
  localparam int DW = 32;
  localparam int BPW = DW / 8;
  localparam int BUSY_CYC = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_ready = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          uart_busy = 1'b0;
  logic          uart_start;
  logic [7:0]    uart_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] frame_words[$];
  logic [7:0]    exp_q[$];
  int  ucnt = 0;
  bit  force_busy = 1'b0;
  int  n_bytes = 0;
  int  n_done = 0;
  int  n_rd = 0;

  fft_frame_sequencer #(
    .FRAME_LEN (FL),
    .DATA_W    (DW),
    .HDR0      (8'hAA),
    .HDR1      (8'h55)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_ready   (rx_ready),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .uart_busy  (uart_busy),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO model: read data appears one cycle after rd_en
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: got rd_en expected none");
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
    end
  end

  // UART model and scoreboard monitor
  always @(negedge clk) begin
    fifo_empty = (fifo_q.size() == 0);
    if (uart_start) begin
      if (uart_busy) begin
        errors++;
        $display("FAIL start_while_busy: got 1 expected 0");
      end
      n_bytes++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_byte: got %02h expected none",
                 uart_data);
      end else begin
        chk($sformatf("byte%0d", n_bytes), uart_data,
            exp_q.pop_front());
      end
      ucnt = BUSY_CYC;
    end else if (ucnt > 0) begin
      ucnt--;
    end
    uart_busy = force_busy || (ucnt > 0);
    if (done) n_done++;
    if (fifo_rd_en) n_rd++;
  end

  task automatic make_frame();
    logic [DW-1:0] w;
    logic [7:0] b;
    logic [7:0] sum;
    sum = '0;
    frame_words.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < FL; i++) begin
      w = $urandom;
      frame_words.push_back(w);
      for (int k = 0; k < BPW; k++) begin
        b = 8'(w >> (8 * (BPW - 1 - k)));
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic load_fifo();
    foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic rise();
    rx_ready = 1'b0;
    step(1);
    rx_ready = 1'b1;
  endtask

  task automatic wait_bytes(input int target, input string nm);
    int t;
    t = 0;
    while (n_bytes < target && t < 3000) begin
      step(1);
      t++;
    end
    chk(nm, longint'(n_bytes >= target), 1);
  endtask

  task automatic wait_done(input string nm);
    int d0;
    int t;
    d0 = n_done;
    t = 0;
    while (n_done == d0 && t < 5000) begin
      step(1);
      t++;
    end
    chk({nm, "_done"}, n_done - d0, 1);
    step(2);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_start"}, uart_start, 0);
    chk({nm, "_data"}, uart_data, 0);
    chk({nm, "_rd_en"}, fifo_rd_en, 0);
  endtask

  int b0, r0, d0;

  initial begin
    step(3);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    step(2);

    // T1: full frame, latency, single done, no restart
    make_frame();
    load_fifo();
    b0 = n_bytes;
    rise();
    step(1);
    chk("t1_lat_start0", uart_start, 0);
    chk("t1_busy", busy, 1);
    step(1);
    chk("t1_lat_start1", uart_start, 1);
    wait_done("t1");
    d0 = n_done;
    step(30);
    chk("t1_no_restart", n_done, d0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_byte_count", n_bytes - b0, exp_q.size() + 2
        + FL * BPW
`ifdef FRAME_CHECKSUM_EN
        + 1
`endif
        );
    chk("t1_rd_count", n_rd, FL);

    // T3: FIFO empty after header
    make_frame();
    b0 = n_bytes;
    rise();
    wait_bytes(b0 + 2, "t3_header");
    r0 = n_rd;
    step(50);
    chk("t3_stall_rd", n_rd, r0);
    chk("t3_stall_bytes", n_bytes, b0 + 2);
    chk("t3_stall_busy", busy, 1);
    load_fifo();
    wait_done("t3");

    // T6: UART busy at frame start
    force_busy = 1'b1;
    step(2);
    make_frame();
    load_fifo();
    b0 = n_bytes;
    rise();
    step(20);
    chk("t6_held", n_bytes, b0);
    force_busy = 1'b0;
    wait_done("t6");
    chk("t6_one_per_byte", n_bytes - b0, 2 + FL * BPW
`ifdef FRAME_CHECKSUM_EN
        + 1
`endif
        );

    // T4: abort after 4th byte, then restart
    make_frame();
    load_fifo();
    b0 = n_bytes;
    d0 = n_done;
    rise();
    wait_bytes(b0 + 4, "t4_four");
    rx_ready = 1'b0;
    step(1);
    chk("t4_busy_drop", busy, 0);
    r0 = n_rd;
    step(30);
    chk("t4_no_rd", n_rd, r0);
    chk("t4_no_done", n_done, d0);
    chk("t4_bytes", n_bytes, b0 + 4);
    exp_q.delete();
    fifo_q.delete();
    step(1);
    make_frame();
    load_fifo();
    rise();
    wait_done("t4_restart");

    // T5: reset mid-word
    make_frame();
    load_fifo();
    b0 = n_bytes;
    rise();
    wait_bytes(b0 + 3, "t5_mid");
    step(2);
    #1;
    rst_n = 1'b0;
    rx_ready = 1'b0;
    #1;
    chk_idle_outputs("t5_rst");
    step(2);
    exp_q.delete();
    fifo_q.delete();
    rst_n = 1'b1;
    b0 = n_bytes;
    r0 = n_rd;
    step(30);
    chk("t5_quiet_bytes", n_bytes, b0);
    chk("t5_quiet_rd", n_rd, r0);
    chk("t5_quiet_busy", busy, 0);
    make_frame();
    load_fifo();
    rise();
    wait_done("t5_after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
